// File: rtl/dram_stream_arbiter_pkg.sv
// Shared types and sizing for the DRAM read-channel arbiter.
package dram_stream_arbiter_pkg;
    localparam int NUM_PE  = 8;
    localparam int BEATS_W = 10;
    localparam int PE_W    = $clog2(NUM_PE);

    typedef enum logic {STREAM_INPUT, STREAM_FILTER} stream_type_t;
    typedef enum logic [1:0] {ARB_IDLE, ARB_CMD, ARB_STREAM, ARB_DONE} arb_state_t;

    typedef struct packed {
        logic [PE_W-1:0]    pe;
        stream_type_t       typ;
        logic [BEATS_W-1:0] beats;
    } burst_req_t;

    function automatic logic [PE_W-1:0] next_pe(input logic [PE_W-1:0] pe);
        return (pe == PE_W'(NUM_PE - 1)) ? '0 : pe + PE_W'(1);
    endfunction
endpackage

// File: rtl/dram_stream_arbiter_if.sv
// PE request / DRAM command / beat steering bundle for the stream arbiter.
interface dram_stream_arbiter_if;
    import dram_stream_arbiter_pkg::*;

    logic [NUM_PE-1:0]              pe_req_valid;
    logic [NUM_PE-1:0]              pe_req_type;
    logic [NUM_PE-1:0][BEATS_W-1:0] pe_req_beats;
    logic [NUM_PE-1:0]              pe_req_ready;
    logic                           dram_cmd_valid;
    logic                           dram_cmd_ready;
    logic [PE_W-1:0]                dram_cmd_pe;
    logic                           dram_cmd_type;
    logic [BEATS_W-1:0]             dram_cmd_beats;
    logic                           dram_rd_valid;
    logic [NUM_PE-1:0]              iaram_wr_en;
    logic [NUM_PE-1:0]              weight_wr_en;
    logic [NUM_PE-1:0]              stream_input_finish;
    logic [NUM_PE-1:0]              stream_filter_finish;
    logic                           busy;
    logic                           protocol_err;

    modport master (
        input  pe_req_valid, pe_req_type, pe_req_beats, dram_cmd_ready, dram_rd_valid,
        output pe_req_ready, dram_cmd_valid, dram_cmd_pe, dram_cmd_type, dram_cmd_beats,
               iaram_wr_en, weight_wr_en, stream_input_finish, stream_filter_finish,
               busy, protocol_err
    );

    modport slave (
        output pe_req_valid, pe_req_type, pe_req_beats, dram_cmd_ready, dram_rd_valid,
        input  pe_req_ready, dram_cmd_valid, dram_cmd_pe, dram_cmd_type, dram_cmd_beats,
               iaram_wr_en, weight_wr_en, stream_input_finish, stream_filter_finish,
               busy, protocol_err
    );
endinterface

// File: rtl/dram_stream_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first request at or after ptr_i, wrapping.
module rr_arbiter #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] req_i,
    input  logic [W-1:0] ptr_i,
    output logic [N-1:0] gnt_o,
    output logic [W-1:0] idx_o,
    output logic         any_o
);
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = |req_i;
        // Scan farthest-first so the closest request to ptr_i is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) idx_o = W'((int'(ptr_i) + i) % N);
        end
        if (any_o) gnt_o[idx_o] = 1'b1;
    end
endmodule

// File: rtl/dram_stream_arbiter.sv
// Shares one DRAM read channel among NUM_PE requesters, one burst at a time.
module dram_stream_arbiter
    import dram_stream_arbiter_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    dram_stream_arbiter_if.master bus
);
    arb_state_t         state_q, state_d;
    logic [PE_W-1:0]    rr_ptr_q, rr_ptr_d;
    burst_req_t         cur_q, cur_d;
    logic [BEATS_W-1:0] cnt_q, cnt_d;
    logic               perr_q, perr_d;

    logic [NUM_PE-1:0]  gnt;
    logic [PE_W-1:0]    gnt_idx;
    logic               gnt_any;

    rr_arbiter #(.N(NUM_PE), .W(PE_W)) u_rr (
        .req_i (bus.pe_req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (gnt),
        .idx_o (gnt_idx),
        .any_o (gnt_any)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= ARB_IDLE;
            rr_ptr_q <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            perr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            perr_q   <= perr_d;
        end
    end

    assign bus.dram_cmd_pe    = cur_q.pe;
    assign bus.dram_cmd_type  = cur_q.typ;
    assign bus.dram_cmd_beats = cur_q.beats;
    assign bus.busy           = (state_q != ARB_IDLE);
    assign bus.protocol_err   = perr_q;

    always_comb begin
        state_d                  = state_q;
        rr_ptr_d                 = rr_ptr_q;
        cur_d                    = cur_q;
        cnt_d                    = cnt_q;
        // Beats outside STREAM are dropped but latched as an error.
        perr_d                   = perr_q | (bus.dram_rd_valid && state_q != ARB_STREAM);
        bus.pe_req_ready         = '0;
        bus.dram_cmd_valid       = 1'b0;
        bus.iaram_wr_en          = '0;
        bus.weight_wr_en         = '0;
        bus.stream_input_finish  = '0;
        bus.stream_filter_finish = '0;

        case (state_q)
            ARB_IDLE: begin
                if (gnt_any) begin
                    bus.pe_req_ready = gnt & {NUM_PE{rst}};
                    cur_d.pe         = gnt_idx;
                    cur_d.typ        = stream_type_t'(bus.pe_req_type[gnt_idx]);
                    cur_d.beats      = bus.pe_req_beats[gnt_idx];
                    state_d          = (cur_d.beats == '0) ? ARB_DONE : ARB_CMD;
                end
            end
            ARB_CMD: begin
                bus.dram_cmd_valid = 1'b1;
                if (bus.dram_cmd_ready) begin
                    cnt_d   = cur_q.beats;
                    state_d = ARB_STREAM;
                end
            end
            ARB_STREAM: begin
                if (bus.dram_rd_valid) begin
                    if (cur_q.typ == STREAM_FILTER) bus.weight_wr_en[cur_q.pe] = 1'b1;
                    else                            bus.iaram_wr_en[cur_q.pe]  = 1'b1;
                    cnt_d = cnt_q - BEATS_W'(1);
                    if (cnt_q == BEATS_W'(1)) state_d = ARB_DONE;
                end
            end
            ARB_DONE: begin
                if (cur_q.typ == STREAM_FILTER) bus.stream_filter_finish[cur_q.pe] = 1'b1;
                else                            bus.stream_input_finish[cur_q.pe]  = 1'b1;
                rr_ptr_d = next_pe(cur_q.pe);
                state_d  = ARB_IDLE;
            end
            default: state_d = ARB_IDLE;
        endcase
    end
endmodule

// File: tb/tb_dram_stream_arbiter.sv
// Directed + randomized bench for dram_stream_arbiter with a transaction-level model.
module tb_dram_stream_arbiter;
    import dram_stream_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    dram_stream_arbiter_if bus();
    dram_stream_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    int n_assert = 0;
    int n_fail   = 0;
    int m_rr     = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NUM_PE-1:0] oh(input int g);
        logic [NUM_PE-1:0] v;
        v = '0;
        v[g] = 1'b1;
        return v;
    endfunction

    // Winner = valid PE with the smallest forward distance from the pointer.
    function automatic int model_pick(input logic [NUM_PE-1:0] v);
        int best = -1;
        int bd   = NUM_PE;
        for (int p = 0; p < NUM_PE; p++) begin
            if (v[p] && ((p - m_rr + NUM_PE) % NUM_PE) < bd) begin
                bd   = (p - m_rr + NUM_PE) % NUM_PE;
                best = p;
            end
        end
        return best;
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_iaram"}, 32'(bus.iaram_wr_en), 0);
        chk({tag, "_weight"}, 32'(bus.weight_wr_en), 0);
        chk({tag, "_fin_in"}, 32'(bus.stream_input_finish), 0);
        chk({tag, "_fin_flt"}, 32'(bus.stream_filter_finish), 0);
    endtask

    task automatic set_req(input int p, input int typ, input int beats);
        bus.pe_req_valid[p] = 1'b1;
        bus.pe_req_type[p]  = typ[0];
        bus.pe_req_beats[p] = BEATS_W'(beats);
    endtask

    // Runs one full burst starting at the grant cycle (called at a negedge, in IDLE).
    task automatic serve(input int cmd_delay, input int gap, output int g);
        logic [NUM_PE-1:0] v;
        int typ, beats;
        v = bus.pe_req_valid;
        g = model_pick(v);
        if (g < 0) g = 0;
        typ   = int'(bus.pe_req_type[g]);
        beats = int'(bus.pe_req_beats[g]);
        #1;
        chk("grant_busy", 32'(bus.busy), 0);
        chk("grant_ready", 32'(bus.pe_req_ready), 32'(oh(g)));
        step();
        bus.pe_req_valid[g] = 1'b0;
        #1;
        chk("post_grant_ready", 32'(bus.pe_req_ready), 0);
        chk("post_grant_busy", 32'(bus.busy), 1);
        if (beats != 0) begin
            for (int d = 0; d <= cmd_delay; d++) begin
                chk("cmd_valid", 32'(bus.dram_cmd_valid), 1);
                chk("cmd_pe", 32'(bus.dram_cmd_pe), 32'(g));
                chk("cmd_type", 32'(bus.dram_cmd_type), 32'(typ));
                chk("cmd_beats", 32'(bus.dram_cmd_beats), 32'(beats));
                chk_quiet("cmd");
                bus.dram_cmd_ready = (d == cmd_delay);
                step();
                bus.dram_cmd_ready = 1'b0;
                #1;
            end
            for (int b = 0; b < beats; b++) begin
                for (int k = 0; k < gap; k++) begin
                    chk("gap_cmd_valid", 32'(bus.dram_cmd_valid), 0);
                    chk_quiet("gap");
                    step();
                    #1;
                end
                bus.dram_rd_valid = 1'b1;
                #1;
                chk("beat_iaram", 32'(bus.iaram_wr_en), (typ == 0) ? 32'(oh(g)) : 0);
                chk("beat_weight", 32'(bus.weight_wr_en), (typ == 1) ? 32'(oh(g)) : 0);
                chk("beat_fin", 32'(bus.stream_input_finish | bus.stream_filter_finish), 0);
                step();
                bus.dram_rd_valid = 1'b0;
                #1;
            end
        end else begin
            chk("zero_cmd_valid", 32'(bus.dram_cmd_valid), 0);
        end
        chk("done_fin_in", 32'(bus.stream_input_finish), (typ == 0) ? 32'(oh(g)) : 0);
        chk("done_fin_flt", 32'(bus.stream_filter_finish), (typ == 1) ? 32'(oh(g)) : 0);
        chk("done_busy", 32'(bus.busy), 1);
        step();
        m_rr = (g + 1) % NUM_PE;
        #1;
        chk("after_busy", 32'(bus.busy), 0);
        chk("after_fin", 32'(bus.stream_input_finish | bus.stream_filter_finish), 0);
    endtask

    initial begin
        int g;
        bus.pe_req_valid   = '0;
        bus.pe_req_type    = '0;
        bus.pe_req_beats   = '0;
        bus.dram_cmd_ready = 1'b0;
        bus.dram_rd_valid  = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_cmd_valid", 32'(bus.dram_cmd_valid), 0);
        chk("rst_perr", 32'(bus.protocol_err), 0);
        chk("rst_ready", 32'(bus.pe_req_ready), 0);
        chk_quiet("rst");
        step();
        rst = 1'b1;
        step();

        // 1: PE0 input, 3 beats, immediate cmd_ready, back-to-back beats
        set_req(0, 0, 3);
        serve(0, 0, g);

        // 2: move pointer to 6 via PE5, then PE2/5/7 together -> 7, 2, 5
        set_req(5, 0, 1);
        serve(0, 0, g);
        set_req(2, 1, 2);
        set_req(5, 0, 1);
        set_req(7, 1, 3);
        serve(1, 0, g);
        serve(0, 1, g);
        serve(2, 0, g);

        // 3: PE1 filter, 2 beats, cmd_ready late, gaps between beats
        set_req(1, 1, 2);
        serve(4, 2, g);

        // 4: PE3 zero-length burst
        set_req(3, 0, 0);
        serve(0, 0, g);

        // Randomized traffic with held requests
        for (int it = 0; it < 40; it++) begin
            for (int p = 0; p < NUM_PE; p++) begin
                if (!bus.pe_req_valid[p] && $urandom_range(0, 2) == 0)
                    set_req(p, int'($urandom_range(0, 1)), int'($urandom_range(0, 5)));
            end
            if (bus.pe_req_valid == '0)
                set_req(int'($urandom_range(0, NUM_PE - 1)), int'($urandom_range(0, 1)), 2);
            serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)), g);
        end
        while (bus.pe_req_valid != '0) serve(0, 0, g);

        // 5: stray beat in IDLE
        chk("perr_before", 32'(bus.protocol_err), 0);
        bus.dram_rd_valid = 1'b1;
        #1;
        chk("stray_iaram", 32'(bus.iaram_wr_en), 0);
        chk("stray_weight", 32'(bus.weight_wr_en), 0);
        step();
        bus.dram_rd_valid = 1'b0;
        #1;
        chk("perr_set", 32'(bus.protocol_err), 1);
        step();
        step();
        chk("perr_sticky", 32'(bus.protocol_err), 1);
        chk("perr_busy", 32'(bus.busy), 0);

        // 6: reset during STREAM after 1 of 4 beats
        set_req(4, 0, 4);
        g = model_pick(bus.pe_req_valid);
        #1;
        chk("t6_grant", 32'(bus.pe_req_ready), 32'(oh(g)));
        step();
        bus.pe_req_valid[4] = 1'b0;
        bus.dram_cmd_ready  = 1'b1;
        step();
        bus.dram_cmd_ready = 1'b0;
        bus.dram_rd_valid  = 1'b1;
        #1;
        chk("t6_beat", 32'(bus.iaram_wr_en), 32'(oh(4)));
        step();
        bus.dram_rd_valid = 1'b0;
        rst = 1'b0;
        m_rr = 0;
        #1;
        chk("t6_busy", 32'(bus.busy), 0);
        chk("t6_cmd_valid", 32'(bus.dram_cmd_valid), 0);
        chk("t6_perr", 32'(bus.protocol_err), 0);
        chk_quiet("t6_rst");
        step();
        #1;
        chk_quiet("t6_hold");
        step();
        rst = 1'b1;
        step();
        chk_quiet("t6_release");
        // pointer back at 0: PE3 must beat PE6
        set_req(6, 1, 1);
        set_req(3, 0, 2);
        serve(0, 0, g);
        serve(1, 1, g);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
